// File: rtl/saradc_sar_ctrl.sv
// rtl/saradc_sar_ctrl.sv - successive-approximation controller for the SAR ADC
`timescale 1ns/1ps
module saradc_sar_ctrl #(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [NBITS-1:0] dac,
    output logic             cmp_en,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] data
);

    // One shared down-counter covers both the sample window and the settle window.
    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = $clog2(NBITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [BW-1:0]     bit_idx, bit_d;
    logic [NBITS-1:0]  dac_d, data_d;
    logic              sample_d, cmp_en_d, busy_d, done_d;
    logic              trial_go;

    // Register state, counters and every output so nothing glitches toward the analog side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            dac     <= '0;
            data    <= '0;
            sample  <= 1'b0;
            cmp_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            dac     <= dac_d;
            data    <= data_d;
            sample  <= sample_d;
            cmp_en  <= cmp_en_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state and next-output logic; dac doubles as the SAR result register.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        bit_d    = bit_idx;
        dac_d    = dac;
        data_d   = data;
        sample_d = 1'b0;
        cmp_en_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        trial_go = 1'b0;

        case (state)
            ST_IDLE: begin
                dac_d = '0;
                if (start) begin
                    state_d  = ST_SAMPLE;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = CW'(SAMPLE_CYCLES - 1);
                end
            end
            ST_SAMPLE: begin
                busy_d = 1'b1;
                if (cnt == '0) begin
                    // Sample switch opens on the same edge the MSB trial is applied.
                    dac_d            = '0;
                    dac_d[NBITS-1]   = 1'b1;
                    bit_d            = BW'(NBITS - 1);
                    trial_go         = 1'b1;
                end else begin
                    cnt_d    = cnt - CW'(1);
                    sample_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                busy_d = 1'b1;
                if (cnt == '0) begin
                    state_d  = ST_COMPARE;
                    cmp_en_d = 1'b1;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            ST_COMPARE: begin
                dac_d[bit_idx] = cmp_in;
                if (bit_idx == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    data_d  = dac_d;
                end else begin
                    busy_d                   = 1'b1;
                    bit_d                    = bit_idx - BW'(1);
                    dac_d[bit_idx - BW'(1)]  = 1'b1;
                    trial_go                 = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                dac_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                dac_d   = '0;
            end
        endcase

        // Start a new bit trial: settle first unless there is no settle time.
        if (trial_go) begin
            if (SETTLE_CYCLES == 0) begin
                state_d  = ST_COMPARE;
                cmp_en_d = 1'b1;
            end else begin
                state_d = ST_SETTLE;
                cnt_d   = CW'(SETTLE_CYCLES - 1);
            end
        end
    end

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// tb/tb_saradc_sar_ctrl.sv - directed self-checking bench for saradc_sar_ctrl
`timescale 1ns/1ps
module tb_saradc_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       cmp_in, cmp2;
    logic       sample, cmp_en, busy, done;
    logic [7:0] dac, data;
    logic       sample2, cmp_en2, busy2, done2;
    logic [3:0] dac2, data2;

    logic [1:0] mode = 2'd0;
    logic [7:0] thr = 8'hA5;
    logic [3:0] thr2 = 4'h9;

    int tests = 0;
    int fails = 0;

    logic       rec_sample [0:63];
    logic       rec_cmp_en [0:63];
    logic       rec_busy   [0:63];
    logic       rec_done   [0:63];
    logic [7:0] rec_dac    [0:63];
    logic [7:0] rec_data   [0:63];
    logic       rec_cmp_en2[0:63];
    logic       rec_done2  [0:63];
    logic [3:0] rec_dac2   [0:63];
    logic [3:0] rec_data2  [0:63];

    logic [7:0] seq_nom [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    logic [3:0] seq_sm  [4] = '{4'h8, 4'hC, 4'hA, 4'h9};

    int n_done, n_overlap, n_sample;

    assign cmp_in = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : (thr >= dac);
    assign cmp2   = (thr2 >= dac2);

    always #5 clk = ~clk;

    saradc_sar_ctrl u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_in (cmp_in),
        .sample (sample),
        .dac    (dac),
        .cmp_en (cmp_en),
        .busy   (busy),
        .done   (done),
        .data   (data)
    );

    saradc_sar_ctrl #(.NBITS(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) u_small (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .cmp_in (cmp2),
        .sample (sample2),
        .dac    (dac2),
        .cmp_en (cmp_en2),
        .busy   (busy2),
        .done   (done2),
        .data   (data2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge in cycle 0; start for cycle c is smask[c]; records cycles 1..ncyc.
    task automatic run(input int ncyc, input logic [63:0] smask, input bit to_small);
        start  = to_small ? 1'b0 : smask[0];
        start2 = to_small ? smask[0] : 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            rec_sample[c]  = sample;
            rec_cmp_en[c]  = cmp_en;
            rec_busy[c]    = busy;
            rec_done[c]    = done;
            rec_dac[c]     = dac;
            rec_data[c]    = data;
            rec_cmp_en2[c] = cmp_en2;
            rec_done2[c]   = done2;
            rec_dac2[c]    = dac2;
            rec_data2[c]   = data2;
            start  = to_small ? 1'b0 : smask[c];
            start2 = to_small ? smask[c] : 1'b0;
        end
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_dac",    32'(dac),    32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_data",   32'(data),   32'd0);
        chk("rst_cmp_en", 32'(cmp_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // nominal conversion, threshold 0xA5
        mode = 2'd0; thr = 8'hA5;
        run(20, 64'h1, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("nom_sample_c%0d", c), 32'(rec_sample[c]), 32'(c <= 2));
            chk($sformatf("nom_cmp_en_c%0d", c), 32'(rec_cmp_en[c]), 32'(c >= 4 && c <= 18 && (c % 2) == 0));
            chk($sformatf("nom_done_c%0d", c),   32'(rec_done[c]),   32'(c == 19));
            chk($sformatf("nom_busy_c%0d", c),   32'(rec_busy[c]),   32'(c <= 18));
            if (c >= 4 && c <= 18 && (c % 2) == 0)
                chk($sformatf("nom_dac_c%0d", c), 32'(rec_dac[c]), 32'(seq_nom[(c - 4) / 2]));
            if (c <= 2)
                chk($sformatf("nom_dac_sample_c%0d", c), 32'(rec_dac[c]), 32'd0);
        end
        chk("nom_data", 32'(rec_data[19]), 32'hA5);
        chk("nom_dac_idle", 32'(rec_dac[20]), 32'd0);

        // extremes
        mode = 2'd1;
        run(20, 64'h1, 1'b0);
        chk("ones_done", 32'(rec_done[19]), 32'd1);
        chk("ones_data", 32'(rec_data[19]), 32'hFF);
        chk("ones_dac",  32'(rec_dac[19]),  32'hFF);
        chk("ones_busy", 32'(rec_busy[19]), 32'd0);
        mode = 2'd2;
        run(20, 64'h1, 1'b0);
        chk("zeros_done", 32'(rec_done[19]), 32'd1);
        chk("zeros_data", 32'(rec_data[19]), 32'h00);
        chk("zeros_busy", 32'(rec_busy[19]), 32'd0);

        // start pulsed in cycles 5, 12, 19 is ignored
        mode = 2'd0; thr = 8'hA5;
        run(24, 64'h1 | (64'h1 << 5) | (64'h1 << 12) | (64'h1 << 19), 1'b0);
        n_done = 0; n_sample = 0;
        for (int c = 1; c <= 24; c++) begin
            n_done += int'(rec_done[c]);
            if (c >= 20) n_sample += int'(rec_sample[c]);
        end
        chk("ign_done_count", 32'(n_done), 32'd1);
        chk("ign_done_c19", 32'(rec_done[19]), 32'd1);
        chk("ign_no_sample", 32'(n_sample), 32'd0);
        chk("ign_idle_busy", 32'(rec_busy[20]), 32'd0);
        chk("ign_data", 32'(rec_data[24]), 32'hA5);

        // continuous start
        run(61, '1, 1'b0);
        n_done = 0; n_overlap = 0;
        for (int c = 1; c <= 61; c++) begin
            n_done += int'(rec_done[c]);
            if (rec_sample[c] && rec_dac[c] != 8'h00) n_overlap++;
        end
        chk("cont_done_c19", 32'(rec_done[19]), 32'd1);
        chk("cont_done_c39", 32'(rec_done[39]), 32'd1);
        chk("cont_done_c59", 32'(rec_done[59]), 32'd1);
        chk("cont_done_count", 32'(n_done), 32'd3);
        chk("cont_bbm", 32'(n_overlap), 32'd0);
        chk("cont_sample_c61", 32'(rec_sample[61]), 32'd1);
        run(25, 64'h0, 1'b0);

        // reset mid-conversion
        thr = 8'h3C;
        run(20, 64'h1, 1'b0);
        chk("rm_first_data", 32'(rec_data[19]), 32'h3C);
        run(10, 64'h1, 1'b0);
        chk("rm_busy_c10", 32'(rec_busy[10]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_sample", 32'(sample), 32'd0);
        chk("rm_dac",    32'(dac),    32'd0);
        chk("rm_cmp_en", 32'(cmp_en), 32'd0);
        chk("rm_busy",   32'(busy),   32'd0);
        chk("rm_done",   32'(done),   32'd0);
        chk("rm_data",   32'(data),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(20, 64'h1, 1'b0);
        chk("rm_sample_c1", 32'(rec_sample[1]), 32'd1);
        chk("rm_data_held", 32'(rec_data[18]), 32'd0);
        chk("rm_done_c19", 32'(rec_done[19]), 32'd1);
        chk("rm_second_data", 32'(rec_data[19]), 32'h3C);

        // parameter corner: NBITS=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=0
        thr2 = 4'h9;
        run(8, 64'h1, 1'b1);
        for (int c = 2; c <= 5; c++) begin
            chk($sformatf("sm_cmp_en_c%0d", c), 32'(rec_cmp_en2[c]), 32'd1);
            chk($sformatf("sm_dac_c%0d", c), 32'(rec_dac2[c]), 32'(seq_sm[c - 2]));
        end
        chk("sm_done_c5", 32'(rec_done2[5]), 32'd0);
        chk("sm_done_c6", 32'(rec_done2[6]), 32'd1);
        chk("sm_done_c7", 32'(rec_done2[7]), 32'd0);
        chk("sm_data", 32'(rec_data2[6]), 32'h9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
